// File: rtl/serial_addsub.sv
// -----------------------------------------------------------------------------
// serial_addsub
//   Bit-serial adder/subtractor: one full-adder cell plus a carry flip-flop,
//   processing one operand bit per clock, LSB first. Operands arrive on a
//   valid/ready handshake. The result and its flags leave on a second
//   valid/ready handshake.
//
// Parameters
//   WIDTH      operand/result width in bits (2..32)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   in_valid   operands a, b, sub, c_in valid this cycle
//   in_ready   block can accept operands (idle)
//   a, b       operands
//   sub        0: a + b + c_in, 1: a - b (c_in ignored)
//   c_in       carry-in for addition
//   out_valid  sum / c_out / ovf hold a completed result
//   out_ready  consumer accepts the result
//   sum        result modulo 2^WIDTH
//   c_out      carry out of the MSB (for subtraction, 1 = no borrow)
//   ovf        signed overflow (carry into MSB xor carry out of MSB)
// -----------------------------------------------------------------------------
module serial_addsub #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             sub,
  input  logic             c_in,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf
);

  localparam int             CW   = $clog2(WIDTH);
  localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  // shift_a doubles as the result register: each sum bit enters at the MSB
  // while the consumed operand bit leaves at the LSB, so after WIDTH shifts
  // it holds the complete sum.
  logic [WIDTH-1:0]  shift_a;
  logic [WIDTH-1:0]  shift_b;
  logic              carry;
  logic [CW-1:0]     cnt;

  logic              s;
  logic              carry_nxt;

  function automatic logic maj3(input logic x, input logic y, input logic z);
    return (x & y) | (x & z) | (y & z);
  endfunction

  assign s         = shift_a[0] ^ shift_b[0] ^ carry;
  assign carry_nxt = maj3(shift_a[0], shift_b[0], carry);
  assign in_ready  = (state == IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      shift_a   <= '0;
      shift_b   <= '0;
      carry     <= 1'b0;
      cnt       <= '0;
      sum       <= '0;
      c_out     <= 1'b0;
      ovf       <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            // Subtraction is a + ~b + 1: invert b and seed the carry with 1.
            shift_a <= a;
            shift_b <= sub ? ~b : b;
            carry   <= sub | c_in;
            cnt     <= '0;
            state   <= RUN;
          end
        end
        RUN: begin
          shift_a <= {s, shift_a[WIDTH-1:1]};
          shift_b <= {1'b0, shift_b[WIDTH-1:1]};
          carry   <= carry_nxt;
          cnt     <= cnt + CW'(1);
          if (cnt == LAST) begin
            // On the MSB, the current carry FF is the carry into the MSB.
            sum       <= {s, shift_a[WIDTH-1:1]};
            c_out     <= carry_nxt;
            ovf       <= carry ^ carry_nxt;
            out_valid <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            state     <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_addsub.sv
// -----------------------------------------------------------------------------
// tb_serial_addsub
//   Self-checking bench for serial_addsub at WIDTH=8 and WIDTH=16. Expected
//   results come from a plain-arithmetic reference model (unsigned sum for the
//   result and carry, signed range check for overflow).
// -----------------------------------------------------------------------------
module tb_serial_addsub;

  localparam int W  = 8;
  localparam int W2 = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_n;

  // WIDTH=8 instance
  logic         in_valid, in_ready, sub, c_in, out_valid, out_ready, c_out, ovf;
  logic [W-1:0] a, b, sum;

  // WIDTH=16 instance
  logic          in_valid_w, in_ready_w, sub_w, c_in_w, out_valid_w, out_ready_w;
  logic          c_out_w, ovf_w;
  logic [W2-1:0] a_w, b_w, sum_w;

  int n_tests = 0;
  int n_fail  = 0;

  serial_addsub #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .sub(sub), .c_in(c_in),
    .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .c_out(c_out), .ovf(ovf)
  );

  serial_addsub #(.WIDTH(W2)) dut_w (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_w), .in_ready(in_ready_w),
    .a(a_w), .b(b_w), .sub(sub_w), .c_in(c_in_w),
    .out_valid(out_valid_w), .out_ready(out_ready_w),
    .sum(sum_w), .c_out(c_out_w), .ovf(ovf_w)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference model: returns {ovf, c_out, sum[31:0]}.
  function automatic logic [33:0] ref_op(input int w, input logic [31:0] oa,
                                         input logic [31:0] ob, input logic osub,
                                         input logic ocin);
    longint m, half, ua, ub, full, sa, sb, r, ci;
    logic [33:0] res;
    m    = longint'(1) << w;
    half = m / 2;
    ua   = longint'(oa) & (m - 1);
    ub   = longint'(ob) & (m - 1);
    ci   = ocin ? longint'(1) : longint'(0);
    // a - b + 2^w equals a + ~b + 1; bit w set means no borrow.
    full = osub ? (ua - ub + m) : (ua + ub + ci);
    sa   = (ua >= half) ? ua - m : ua;
    sb   = (ub >= half) ? ub - m : ub;
    r    = osub ? (sa - sb) : (sa + sb + ci);
    res        = '0;
    res[31:0]  = 32'(full & (m - 1));
    res[32]    = full[w];
    res[33]    = (r >= half) || (r < -half);
    return res;
  endfunction

  // Present operands once, then count cycles until out_valid.
  task automatic launch(input logic [W-1:0] oa, input logic [W-1:0] ob,
                        input logic osub, input logic ocin, input string tag);
    int guard;
    int lat;
    guard = 0;
    while (!in_ready && guard < 50) begin
      tick();
      guard++;
    end
    chk({tag, " in_ready"}, in_ready, 1);
    a = oa; b = ob; sub = osub; c_in = ocin; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    // Scramble operands during RUN; they must be ignored.
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
    lat = 0;
    while (!out_valid && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, W);
  endtask

  task automatic check_result(input logic [33:0] e, input string tag);
    chk({tag, " sum"},   sum,   e[W-1:0]);
    chk({tag, " c_out"}, c_out, e[32]);
    chk({tag, " ovf"},   ovf,   e[33]);
  endtask

  task automatic handshake(input logic [33:0] e, input string tag);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk({tag, " out_valid cleared"}, out_valid, 0);
    chk({tag, " in_ready after"},    in_ready,  1);
    chk({tag, " sum held in idle"},  sum,       e[W-1:0]);
  endtask

  task automatic do_op(input logic [W-1:0] oa, input logic [W-1:0] ob,
                       input logic osub, input logic ocin, input string tag);
    logic [33:0] e;
    e = ref_op(W, 32'(oa), 32'(ob), osub, ocin);
    launch(oa, ob, osub, ocin, tag);
    check_result(e, tag);
    handshake(e, tag);
  endtask

  task automatic do_op16(input logic [W2-1:0] oa, input logic [W2-1:0] ob,
                         input logic osub, input logic ocin, input string tag);
    logic [33:0] e;
    int lat;
    e = ref_op(W2, 32'(oa), 32'(ob), osub, ocin);
    chk({tag, " in_ready"}, in_ready_w, 1);
    a_w = oa; b_w = ob; sub_w = osub; c_in_w = ocin; in_valid_w = 1'b1;
    tick();
    in_valid_w = 1'b0;
    lat = 0;
    while (!out_valid_w && lat < 100) begin
      tick();
      lat++;
    end
    chk({tag, " latency"}, lat, W2);
    chk({tag, " sum"},   sum_w,   e[W2-1:0]);
    chk({tag, " c_out"}, c_out_w, e[32]);
    chk({tag, " ovf"},   ovf_w,   e[33]);
    out_ready_w = 1'b1;
    tick();
    out_ready_w = 1'b0;
    chk({tag, " out_valid cleared"}, out_valid_w, 0);
  endtask

  initial begin
    logic [33:0] e;
    logic [33:0] expq[$];
    logic        acc_prev;
    int          nacc, nres, last_t, cyc;

    rst_n = 1'b0;
    in_valid = 0; a = '0; b = '0; sub = 0; c_in = 0; out_ready = 0;
    in_valid_w = 0; a_w = '0; b_w = '0; sub_w = 0; c_in_w = 0; out_ready_w = 0;
    tick();
    tick();
    chk("reset sum",       sum,       0);
    chk("reset c_out",     c_out,     0);
    chk("reset ovf",       ovf,       0);
    chk("reset out_valid", out_valid, 0);
    chk("reset in_ready",  in_ready,  1);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    chk("post-reset in_ready", in_ready, 1);

    // Directed cases, including wrap, carry-in and subtract boundaries.
    do_op(8'h5A, 8'h3C, 1'b0, 1'b0, "add 5A+3C");
    do_op(8'hFF, 8'h01, 1'b0, 1'b0, "add FF+01");
    do_op(8'hFF, 8'h01, 1'b0, 1'b1, "add FF+01+1");
    do_op(8'h10, 8'h20, 1'b1, 1'b0, "sub 10-20");
    do_op(8'h80, 8'h01, 1'b1, 1'b1, "sub 80-01");
    do_op(8'h7F, 8'h00, 1'b0, 1'b1, "add 7F+00+1");
    do_op(8'h00, 8'h00, 1'b1, 1'b0, "sub 00-00");
    do_op(8'h80, 8'h80, 1'b0, 1'b0, "add 80+80");

    // Result held while the consumer stalls; inputs toggling are ignored.
    e = ref_op(W, 32'h0000_00C3, 32'h0000_0071, 1'b0, 1'b1);
    launch(8'hC3, 8'h71, 1'b0, 1'b1, "stall");
    check_result(e, "stall");
    for (int i = 0; i < 5; i++) begin
      in_valid = ~in_valid;
      a = W'($urandom);
      tick();
      check_result(e, "stall hold");
      chk("stall out_valid", out_valid, 1);
      chk("stall in_ready",  in_ready,  0);
    end
    // in_valid high across the result handshake must not be accepted.
    in_valid = 1'b1;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    in_valid = 1'b0;
    chk("no same-cycle accept in_ready", in_ready, 1);
    chk("no same-cycle accept out_valid", out_valid, 0);
    chk("stall sum after", sum, e[W-1:0]);

    // Asynchronous reset mid-operation aborts it.
    a = 8'h33; b = 8'h44; sub = 0; c_in = 0; in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick(); tick();
    rst_n = 1'b0;
    #1;
    chk("abort out_valid", out_valid, 0);
    chk("abort sum",       sum,       0);
    chk("abort in_ready",  in_ready,  1);
    tick();
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("abort no result", out_valid, 0);
    end
    do_op(8'h01, 8'h02, 1'b0, 1'b0, "after abort");

    // Random operations.
    for (int i = 0; i < 20; i++) begin
      do_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), "random");
    end

    // Back-to-back with in_valid and out_ready held high.
    nacc = 0; nres = 0; last_t = -1; cyc = 0;
    a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
    in_valid = 1'b1;
    out_ready = 1'b1;
    acc_prev = in_ready && in_valid;
    for (int c = 0; c < 80 && nres < 4; c++) begin
      tick();
      cyc++;
      if (acc_prev) begin
        expq.push_back(ref_op(W, 32'(a), 32'(b), sub, c_in));
        nacc++;
        if (nacc == 4) in_valid = 1'b0;
        a = W'($urandom); b = W'($urandom); sub = 1'($urandom); c_in = 1'($urandom);
      end
      if (out_valid) begin
        if (expq.size() == 0) begin
          chk("b2b unexpected result", 1, 0);
        end else begin
          e = expq.pop_front();
          check_result(e, "b2b");
        end
        if (last_t >= 0) chk("b2b interval", cyc - last_t, W + 2);
        last_t = cyc;
        nres++;
      end
      acc_prev = in_ready && in_valid;
    end
    in_valid = 1'b0;
    out_ready = 1'b0;
    chk("b2b result count", nres, 4);

    // WIDTH=16 instance.
    do_op16(16'h005A, 16'h003C, 1'b0, 1'b0, "w16 5A+3C");
    do_op16(16'h7FFF, 16'h0001, 1'b0, 1'b0, "w16 7FFF+1");
    do_op16(16'h8000, 16'h0001, 1'b1, 1'b0, "w16 8000-1");
    for (int i = 0; i < 3; i++) begin
      do_op16(W2'($urandom), W2'($urandom), 1'($urandom), 1'($urandom), "w16 random");
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
